// File: rtl/video_line_reader.sv
// video_line_reader: streams one display line of packed RGB565 pixels
// from the read port of the video frame memory to the LCD path.
//
// Ports:
//   clk, reset           - sole clock, synchronous active-high reset
//   start                - one-cycle line request (ignored while busy)
//   base_addr            - first memory word address of the line
//   word_count           - words to read, 0..1024
//   busy, done           - line in progress / one-cycle completion pulse
//   mem_adr, mem_ce      - read address and enable to memory port B
//   mem_oce              - tied high (memory in bypass read mode)
//   mem_dout             - read data, one cycle after mem_ce
//   pix_data, pix_valid  - pixel stream, low half of each word first
//   pix_ready            - sink accepts pixel when valid & ready
//   pix_last             - marks the final pixel of the line
//   underrun_cnt         - saturating starvation counter, present only
//                          when VIDEO_RD_UNDERRUN_EN is defined
module video_line_reader #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int PIX_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_adr,
    output logic              mem_ce,
    output logic              mem_oce,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_last
`ifdef VIDEO_RD_UNDERRUN_EN
    ,
    output logic [15:0]       underrun_cnt
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W:0] ONE_W = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] ZERO_W = '0;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    state_t state;
    state_t state_nx;

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   issue_left;
    logic [ADDR_W:0]   pop_left;
    logic              in_flight;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [DATA_W-1:0] head;
    logic              high_half;

    logic start_ok;
    logic issue;
    logic push;
    logic fire;
    logic pop;
    logic last_word;
    logic last_fire;
    logic room;

    // Room is judged on words already buffered plus the read still in
    // flight, so a returning word always finds a free slot.
    assign room      = (fifo_cnt + CNT_W'(in_flight)) < DEPTH_C;
    assign start_ok  = (state == IDLE) && start;
    assign push      = in_flight;
    assign head      = fifo_mem[rd_ptr];
    assign last_word = (pop_left == ONE_W);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        mem_ce    = 1'b0;
        mem_adr   = addr;
        mem_oce   = 1'b1;
        issue     = 1'b0;
        pix_valid = (fifo_cnt != '0);
        pix_data  = head[PIX_W-1:0];
        pix_last  = 1'b0;
        fire      = 1'b0;
        pop       = 1'b0;
        last_fire = 1'b0;

        if (high_half) begin
            pix_data = head[2*PIX_W-1:PIX_W];
        end
        pix_last  = pix_valid && high_half && last_word;
        fire      = pix_valid && pix_ready;
        pop       = fire && high_half;
        last_fire = pop && last_word;

        unique case (state)
            IDLE: begin
                if (start && (word_count != ZERO_W)) begin
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                busy  = 1'b1;
                issue = (issue_left != ZERO_W) && room;
                if (issue && (issue_left == ONE_W)) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (last_fire) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        mem_ce = issue;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr       <= '0;
            issue_left <= '0;
            pop_left   <= '0;
            in_flight  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            high_half  <= 1'b0;
            done       <= 1'b0;
        end else begin
            done      <= (start_ok && (word_count == ZERO_W)) || last_fire;
            in_flight <= issue;

            if (start_ok) begin
                addr       <= base_addr;
                issue_left <= word_count;
                pop_left   <= word_count;
            end else begin
                if (issue) begin
                    // natural roll-over gives the 1023 -> 0 wrap
                    addr       <= addr + 1'b1;
                    issue_left <= issue_left - ONE_W;
                end
                if (pop) begin
                    pop_left <= pop_left - ONE_W;
                end
            end

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase

            if (fire) begin
                high_half <= ~high_half;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_dout;
        end
    end

`ifdef VIDEO_RD_UNDERRUN_EN
    logic seen_first;

    // Starvation only counts once the line has produced its first pixel;
    // the initial fetch latency is expected and not an underrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            seen_first   <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            if (start_ok) begin
                seen_first <= 1'b0;
            end else if (busy && pix_valid) begin
                seen_first <= 1'b1;
            end
            if (busy && seen_first && pix_ready && !pix_valid &&
                (underrun_cnt != 16'hFFFF)) begin
                underrun_cnt <= underrun_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_video_line_reader.sv
// tb_video_line_reader: scoreboard bench for video_line_reader with a
// behavioural port-B memory model and a line-level pixel reference.
module tb_video_line_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] word_count;
    logic        busy;
    logic        done;
    logic [9:0]  mem_adr;
    logic        mem_ce;
    logic        mem_oce;
    logic [31:0] mem_dout;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_last;
`ifdef VIDEO_RD_UNDERRUN_EN
    logic [15:0] underrun_cnt;
    int          exp_ur;
    bit          ur_seen;
`endif

    video_line_reader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .mem_adr    (mem_adr),
        .mem_ce     (mem_ce),
        .mem_oce    (mem_oce),
        .mem_dout   (mem_dout),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
`ifdef VIDEO_RD_UNDERRUN_EN
        .underrun_cnt (underrun_cnt),
`endif
        .pix_last   (pix_last)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [1024];

    always @(posedge clk) begin
        if (mem_ce) mem_dout <= mem[mem_adr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // {is_high_half, is_last, pixel}
    logic [17:0] exp_pix [$];
    logic [9:0]  exp_adr [$];

    int errors = 0;
    int checks = 0;
    int pix_cnt = 0;
    int done_cnt = 0;
    int outstanding = 0;
    int first_valid_cyc = 0;
    int last_fire_cyc = 0;
    int done_cyc = 0;
    bit seen_valid = 0;
    bit hold_pend = 0;
    logic [15:0] held_data;
    logic held_last;
    int ready_mode = 0;
    int phase = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Monitor / scoreboard: samples at the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            logic [17:0] e;
            bit popw;
            popw = 0;
`ifdef VIDEO_RD_UNDERRUN_EN
            if (busy && ur_seen && pix_ready && !pix_valid &&
                exp_ur < 16'hFFFF) exp_ur++;
            if (busy && pix_valid) ur_seen = 1;
`endif
            if (hold_pend && pix_valid) begin
                chk("hold_data", pix_data, held_data);
                chk("hold_last", pix_last, held_last);
            end
            if (mem_ce) begin
                chk("fifo_room", outstanding + 1 <= 4, 1);
                if (exp_adr.size() == 0) fail_now("unexpected_read");
                else chk("mem_adr", mem_adr, exp_adr.pop_front());
            end
            if (pix_valid && !seen_valid) begin
                seen_valid = 1;
                first_valid_cyc = cyc;
            end
            if (pix_valid && pix_ready) begin
                if (exp_pix.size() == 0) fail_now("unexpected_pixel");
                else begin
                    e = exp_pix.pop_front();
                    chk("pix_data", pix_data, e[15:0]);
                    chk("pix_last", pix_last, e[16]);
                    if (e[16]) last_fire_cyc = cyc;
                    popw = e[17];
                end
                pix_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_at_done", busy, 0);
            end
            outstanding += (mem_ce ? 1 : 0) - (popw ? 1 : 0);
            hold_pend = pix_valid && !pix_ready;
            held_data = pix_data;
            held_last = pix_last;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: pix_ready = 1'b1;
                1: begin
                    pix_ready = (phase == 0);
                    phase = (phase + 1) % 3;
                end
                default: pix_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic push_line(input int base, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            logic [31:0] w;
            logic [9:0] a;
            a = 10'((base + i) % 1024);
            w = mem[a];
            exp_adr.push_back(a);
            exp_pix.push_back({1'b0, 1'b0, w[15:0]});
            exp_pix.push_back({1'b1, i == cnt - 1, w[31:16]});
        end
    endtask

    task automatic pulse_start(input int base, input int cnt,
                               output int c0);
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = 10'(base);
        word_count = 11'(cnt);
        c0 = cyc;
`ifdef VIDEO_RD_UNDERRUN_EN
        ur_seen = 0;
`endif
        @(posedge clk);
        #1;
        start = 1'b0;
        base_addr = 10'($urandom);
        word_count = 11'($urandom_range(0, 1024));
    endtask

    task automatic run_line(input int base, input int cnt,
                            input bit extra, output int c0);
        int d0;
        int p0;
        int t;
        push_line(base, cnt);
        d0 = done_cnt;
        p0 = pix_cnt;
        seen_valid = 0;
        pulse_start(base, cnt, c0);
        t = 0;
        while (done_cnt == d0 && t < 5000) begin
            if (extra && (t == 4 || t == 9) && busy) begin
                start = 1'b1;
                base_addr = 10'($urandom);
                word_count = 11'($urandom_range(1, 50));
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            t++;
        end
        start = 1'b0;
        if (done_cnt == d0) fail_now("done_timeout");
        repeat (3) @(posedge clk);
        #1;
        chk("one_done", done_cnt - d0, 1);
        chk("pix_count", pix_cnt - p0, 2 * cnt);
        chk("pix_queue_empty", exp_pix.size(), 0);
        chk("adr_queue_empty", exp_adr.size(), 0);
`ifdef VIDEO_RD_UNDERRUN_EN
        chk("underrun_cnt", underrun_cnt, exp_ur);
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_ce", mem_ce, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_last", pix_last, 0);
        chk("rst_mem_adr", mem_adr, 0);
        chk("rst_mem_oce", mem_oce, 1);
        exp_pix.delete();
        exp_adr.delete();
        outstanding = 0;
        hold_pend = 0;
`ifdef VIDEO_RD_UNDERRUN_EN
        exp_ur = 0;
        chk("rst_underrun", underrun_cnt, 0);
`endif
        reset = 1'b0;
    endtask

    initial begin
        int c0;
        int p0;
        int t;
        reset = 1'b1;
        start = 1'b0;
        base_addr = '0;
        word_count = '0;
        pix_ready = 1'b1;
        mem_dout = '0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) mem[16 + i] = 32'hBBBBAAAA + i;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // directed line with latency checks
        ready_mode = 0;
        run_line(16, 4, 0, c0);
        chk("first_valid_lat", first_valid_cyc - c0, 3);
        chk("done_lat", done_cyc - last_fire_cyc, 1);

        // address wrap
        run_line(10'h3FE, 4, 0, c0);

        // throttled sink
        ready_mode = 1;
        run_line($urandom_range(0, 1023), 16, 0, c0);

        // starts during busy are dropped
        ready_mode = 2;
        run_line($urandom_range(0, 1023), 12, 1, c0);

        // zero-length line
        begin
            int d0;
            d0 = done_cnt;
            pulse_start(5, 0, c0);
            repeat (3) @(posedge clk);
            #1;
            chk("zero_done_cnt", done_cnt - d0, 1);
            chk("zero_done_lat", done_cyc - c0, 1);
        end

        // reset mid-line after 3 pixels
        ready_mode = 0;
        push_line(100, 8);
        p0 = pix_cnt;
        pulse_start(100, 8, c0);
        t = 0;
        while (pix_cnt - p0 < 3 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (pix_cnt - p0 < 3) fail_now("mid_line_timeout");
        do_reset();
        run_line($urandom_range(0, 1023), 2, 0, c0);

        // randomized lines
        for (int n = 0; n < 8; n++) begin
            ready_mode = (n % 3 == 0) ? 0 : 2;
            run_line($urandom_range(0, 1023), $urandom_range(1, 40),
                     n[0], c0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
